// File: rtl/microwave_cook_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : microwave_cook_sequencer
// Brief    : Cook-cycle FSM with keypad/preset entry, BCD mm:ss countdown,
//            magnetron power gating and end-of-cook buzzer.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module microwave_cook_sequencer #(
    parameter int TICK_DIV   = 50000000,
    parameter int BUZZ_SECS  = 3,
    parameter int ADD_SECS   = 30,
    parameter int FULL_POWER = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        door_open,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        preset_valid,
    input  logic [15:0] preset_time,
    input  logic [7:0]  preset_power,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic [7:0]  power,
    output logic        magnetron_en,
    output logic        buzzer,
    output logic [2:0]  state
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BZ_W = (BUZZ_SECS > 1) ? $clog2(BUZZ_SECS + 1) : 1;
    localparam logic [PS_W-1:0] C_PS_MAX  = PS_W'(TICK_DIV - 1);
    localparam logic [BZ_W-1:0] C_BZ_LAST = BZ_W'(BUZZ_SECS - 1);
    localparam logic [7:0]      C_FULL    = 8'(FULL_POWER);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_COOK   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     time_q, time_d;
    logic [7:0]      power_reg_q, power_reg_d;
    logic [PS_W-1:0] prescaler_q, prescaler_d;
    logic [BZ_W-1:0] buzz_cnt_q, buzz_cnt_d;
    logic            buzzer_q, buzzer_d;
    logic            start_prev_q, stop_prev_q;
    logic [15:0]     cook_time;

    logic        w_start_evt;
    logic        w_stop_evt;
    logic        w_tick;
    logic [15:0] w_dec_time;

    // Adds seconds to a BCD mm:ss value, carrying into minutes and
    // saturating at 99:59. With add=0 it normalises seconds > 59.
    function automatic logic [15:0] add_time(input logic [15:0] t, input int add);
        int s;
        int m;
        s = int'(t[7:4]) * 10 + int'(t[3:0]) + add;
        m = int'(t[15:12]) * 10 + int'(t[11:8]) + s / 60;
        s = s % 60;
        if (m > 99) begin
            m = 99;
            s = 59;
        end
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] dec_time(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else if (t[7:4] != 4'd0) begin
            r[7:4] = t[7:4] - 4'd1;
            r[3:0] = 4'd9;
        end else begin
            r[7:0] = 8'h59;
            if (t[11:8] != 4'd0) begin
                r[11:8] = t[11:8] - 4'd1;
            end else begin
                r[15:12] = t[15:12] - 4'd1;
                r[11:8]  = 4'd9;
            end
        end
        return r;
    endfunction

    assign w_start_evt = start & ~start_prev_q;
    assign w_stop_evt  = stop & ~stop_prev_q;
    assign w_tick      = (prescaler_q == C_PS_MAX);
    assign w_dec_time  = dec_time(time_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            time_q       <= 16'h0000;
            power_reg_q  <= C_FULL;
            prescaler_q  <= '0;
            buzz_cnt_q   <= '0;
            buzzer_q     <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_q       <= time_d;
            power_reg_q  <= power_reg_d;
            prescaler_q  <= prescaler_d;
            buzz_cnt_q   <= buzz_cnt_d;
            buzzer_q     <= buzzer_d;
            start_prev_q <= start;
            stop_prev_q  <= stop;
        end
    end

    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        power_reg_d = power_reg_q;
        prescaler_d = prescaler_q;
        buzz_cnt_d  = buzz_cnt_q;
        buzzer_d    = buzzer_q;
        cook_time   = time_q;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (w_stop_evt) begin
                    time_d      = 16'h0000;
                    power_reg_d = C_FULL;
                    state_d     = ST_IDLE;
                end else if (door_open) begin
                    state_d = state_q;
                end else if (w_start_evt) begin
                    if ((state_q == ST_IDLE) || (time_q == 16'h0000)) begin
                        time_d      = add_time(16'h0000, ADD_SECS);
                        power_reg_d = C_FULL;
                    end else begin
                        time_d = add_time(time_q, 0);
                    end
                    prescaler_d = '0;
                    state_d     = ST_COOK;
                end else if (preset_valid) begin
                    time_d      = preset_time;
                    power_reg_d = preset_power;
                    state_d     = ST_ENTRY;
                end else if (digit_valid && (digit <= 4'd9)) begin
                    time_d  = {time_q[11:0], digit};
                    state_d = ST_ENTRY;
                end
            end

            ST_COOK: begin
                if (w_stop_evt || door_open) begin
                    state_d = ST_PAUSED;
                end else begin
                    if (w_tick) begin
                        prescaler_d = '0;
                        cook_time   = w_dec_time;
                    end else begin
                        prescaler_d = prescaler_q + 1'b1;
                    end
                    // A +30 s press landing on a tick applies after the decrement.
                    if (w_start_evt) begin
                        cook_time = add_time(cook_time, ADD_SECS);
                    end
                    time_d = cook_time;
                    if (cook_time == 16'h0000) begin
                        state_d     = ST_DONE;
                        buzzer_d    = 1'b1;
                        prescaler_d = '0;
                        buzz_cnt_d  = '0;
                    end
                end
            end

            ST_PAUSED: begin
                if (w_stop_evt) begin
                    time_d      = 16'h0000;
                    power_reg_d = C_FULL;
                    state_d     = ST_IDLE;
                end else if (!door_open && w_start_evt) begin
                    prescaler_d = '0;
                    state_d     = ST_COOK;
                end
            end

            ST_DONE: begin
                if (w_stop_evt) begin
                    buzzer_d    = 1'b0;
                    power_reg_d = C_FULL;
                    state_d     = ST_IDLE;
                end else if (w_tick) begin
                    prescaler_d = '0;
                    if (buzz_cnt_q == C_BZ_LAST) begin
                        buzz_cnt_d  = '0;
                        buzzer_d    = 1'b0;
                        power_reg_d = C_FULL;
                        state_d     = ST_IDLE;
                    end else begin
                        buzz_cnt_d = buzz_cnt_q + 1'b1;
                    end
                end else begin
                    prescaler_d = prescaler_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign magnetron_en = (state_q == ST_COOK) & ~door_open;
    assign power        = magnetron_en ? power_reg_q : 8'd0;
    assign buzzer       = buzzer_q;
    assign state        = state_q;
    assign min_tens     = time_q[15:12];
    assign min_ones     = time_q[11:8];
    assign sec_tens     = time_q[7:4];
    assign sec_ones     = time_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_microwave_cook_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_microwave_cook_sequencer
// Brief    : Directed scoreboard bench for the cook sequencer (TICK_DIV=4).
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_microwave_cook_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        door_open = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        preset_valid = 1'b0;
    logic [15:0] preset_time = 16'h0000;
    logic [7:0]  preset_power = 8'd0;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic [7:0]  power;
    logic        magnetron_en;
    logic        buzzer;
    logic [2:0]  state;

    typedef struct {
        string       tag;
        logic [28:0] vec;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    microwave_cook_sequencer #(
        .TICK_DIV  (4),
        .BUZZ_SECS (3),
        .ADD_SECS  (30),
        .FULL_POWER(100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .door_open   (door_open),
        .digit_valid (digit_valid),
        .digit       (digit),
        .preset_valid(preset_valid),
        .preset_time (preset_time),
        .preset_power(preset_power),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .power       (power),
        .magnetron_en(magnetron_en),
        .buzzer      (buzzer),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic [15:0] tm,
                        input logic [7:0] pw, input logic mg, input logic bz);
        exp_t e;
        e.tag = tag;
        e.vec = {st, tm, pw, mg, bz};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [28:0] obs;
        obs = {state, min_tens, min_ones, sec_tens, sec_ones, power, magnetron_en, buzzer};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                errors++;
                $error("FAIL %s: observed st=%0d t=%h pw=%0d mg=%b bz=%b expected st=%0d t=%h pw=%0d mg=%b bz=%b",
                       e.tag, obs[28:26], obs[25:10], obs[9:2], obs[1], obs[0],
                       e.vec[28:26], e.vec[25:10], e.vec[9:2], e.vec[1], e.vec[0]);
            end
        end
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step(1);
        digit_valid = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic press_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    initial begin
        step(3);
        push("reset_state", 3'd0, 16'h0000, 8'd0, 1'b0, 1'b0);
        pop_check();
        reset = 1'b1;
        step(1);

        // Entry 1,3,<invalid 12>,0 then countdown
        push("digit_entry", 3'd1, 16'h0130, 8'd0, 1'b0, 1'b0);
        key(4'd1); key(4'd3); key(4'hC); key(4'd0);
        pop_check();
        push("start_cook", 3'd2, 16'h0130, 8'd100, 1'b1, 1'b0);
        press_start();
        pop_check();
        push("no_early_tick", 3'd2, 16'h0130, 8'd100, 1'b1, 1'b0);
        step(3);
        pop_check();
        push("first_tick", 3'd2, 16'h0129, 8'd100, 1'b1, 1'b0);
        step(1);
        pop_check();
        push("tick31_borrow", 3'd2, 16'h0059, 8'd100, 1'b1, 1'b0);
        step(120);
        pop_check();
        push("at_0010", 3'd2, 16'h0010, 8'd100, 1'b1, 1'b0);
        step(196);
        pop_check();

        // +30 s presses, prescaler keeps running
        push("add30_first", 3'd2, 16'h0040, 8'd100, 1'b1, 1'b0);
        press_start();
        pop_check();
        step(1);
        push("add30_carry", 3'd2, 16'h0110, 8'd100, 1'b1, 1'b0);
        press_start();
        pop_check();
        push("tick_after_add", 3'd2, 16'h0109, 8'd100, 1'b1, 1'b0);
        step(1);
        pop_check();
        push("stop_pause", 3'd3, 16'h0109, 8'd0, 1'b0, 1'b0);
        press_stop();
        pop_check();
        step(1);
        push("stop_clear", 3'd0, 16'h0000, 8'd0, 1'b0, 1'b0);
        press_stop();
        pop_check();

        // Saturation at 99:59
        push("entry_9945", 3'd1, 16'h9945, 8'd0, 1'b0, 1'b0);
        key(4'd9); key(4'd9); key(4'd4); key(4'd5);
        pop_check();
        push("cook_9945", 3'd2, 16'h9945, 8'd100, 1'b1, 1'b0);
        press_start();
        pop_check();
        step(1);
        push("saturate", 3'd2, 16'h9959, 8'd100, 1'b1, 1'b0);
        press_start();
        pop_check();
        step(1);
        press_stop();
        step(1);
        press_stop();

        // Normalise 90 s, door interlock, resume
        push("normalise", 3'd2, 16'h0130, 8'd100, 1'b1, 1'b0);
        key(4'd9); key(4'd0);
        press_start();
        pop_check();
        step(1);
        door_open = 1'b1;
        #1;
        push("door_cut", 3'd2, 16'h0130, 8'd0, 1'b0, 1'b0);
        pop_check();
        push("door_pause", 3'd3, 16'h0130, 8'd0, 1'b0, 1'b0);
        step(1);
        pop_check();
        push("door_frozen", 3'd3, 16'h0130, 8'd0, 1'b0, 1'b0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        pop_check();
        door_open = 1'b0;
        step(1);
        push("resume", 3'd2, 16'h0130, 8'd100, 1'b1, 1'b0);
        press_start();
        pop_check();
        push("resume_hold", 3'd2, 16'h0130, 8'd100, 1'b1, 1'b0);
        step(3);
        pop_check();
        push("resume_tick", 3'd2, 16'h0129, 8'd100, 1'b1, 1'b0);
        step(1);
        pop_check();
        press_stop();
        step(1);
        press_stop();

        // Preset run to completion and buzzer window
        push("preset_entry", 3'd1, 16'h0200, 8'd0, 1'b0, 1'b0);
        preset_valid = 1'b1;
        preset_time  = 16'h0200;
        preset_power = 8'd60;
        step(1);
        preset_valid = 1'b0;
        pop_check();
        push("preset_cook", 3'd2, 16'h0200, 8'd60, 1'b1, 1'b0);
        press_start();
        pop_check();
        push("last_second", 3'd2, 16'h0001, 8'd60, 1'b1, 1'b0);
        step(479);
        pop_check();
        push("done_buzz", 3'd4, 16'h0000, 8'd0, 1'b0, 1'b1);
        step(1);
        pop_check();
        push("done_ignores_start", 3'd4, 16'h0000, 8'd0, 1'b0, 1'b1);
        press_start();
        pop_check();
        push("buzz_cycle12", 3'd4, 16'h0000, 8'd0, 1'b0, 1'b1);
        step(10);
        pop_check();
        push("buzz_off", 3'd0, 16'h0000, 8'd0, 1'b0, 1'b0);
        step(1);
        pop_check();

        // Quick-start, simultaneous start+stop, async reset
        step(1);
        push("quick_start", 3'd2, 16'h0030, 8'd100, 1'b1, 1'b0);
        press_start();
        pop_check();
        step(1);
        push("start_stop_same", 3'd3, 16'h0030, 8'd0, 1'b0, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        pop_check();
        step(1);
        push("resume_again", 3'd2, 16'h0030, 8'd100, 1'b1, 1'b0);
        press_start();
        pop_check();
        step(2);
        reset = 1'b0;
        #1;
        push("async_reset", 3'd0, 16'h0000, 8'd0, 1'b0, 1'b0);
        pop_check();
        push("reset_held", 3'd0, 16'h0000, 8'd0, 1'b0, 1'b0);
        step(2);
        pop_check();
        reset = 1'b1;
        step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
